// File: rtl/ber_pkg.sv
// Shared types and helpers for the BER window counter.
package ber_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} ber_state_t;

    // Width needed to hold a popcount of a w-bit word (0..w inclusive).
    function automatic int pcw(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/ber_xor_popcount.sv
// Combinational bit-error count of one word pair: popcount(a ^ b).
module ber_xor_popcount
    import ber_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0]       a,
    input  logic [W-1:0]       b,
    output logic [pcw(W)-1:0]  out
);

    localparam int PCW = pcw(W);

    logic [W-1:0] d;

    assign d = a ^ b;

    always_comb begin
        // NOTE: the default ahead of the loop keeps every path assigned, so no latch is inferred.
        out = '0;
        for (int i = 0; i < W; i++) begin
            out = out + PCW'(d[i]);
        end
    end

endmodule

// File: rtl/ber_window_counter.sv
// Windowed bit-error counter: two-stage popcount/accumulate over WIN_WORDS beats.
// Define BER_SAT_EN to make err_count saturate and drive a sticky overflow flag.
module ber_window_counter
    import ber_pkg::*;
#(
    parameter int W         = 32,
    parameter int WIN_WORDS = 1024,
    parameter int CW        = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [W-1:0]                   tx_word,
    input  logic [W-1:0]                   rx_word,
    output logic [CW-1:0]                  err_count,
    output logic [$clog2(WIN_WORDS+1)-1:0] word_count,
    output logic                           busy,
    output logic                           done,
    output logic                           overflow
);

    localparam int PCW = pcw(W);
    localparam int WCW = $clog2(WIN_WORDS + 1);

    ber_state_t     state;
    logic [PCW-1:0] pc_d;
    logic [PCW-1:0] pc_q;
    logic           v_q;
    logic           restart;
    logic           accept;

    ber_xor_popcount #(.W(W)) u_popcount (
        .a   (tx_word),
        .b   (rx_word),
        .out (pc_d)
    );

    // A start during DRAIN is ignored so the final beat always lands.
    assign restart  = start && (state != DRAIN);
    assign in_ready = (state == RUN) && !start;
    assign accept   = in_valid && in_ready;
    assign busy     = (state == RUN) || (state == DRAIN);
    assign done     = (state == DONE);

`ifdef BER_SAT_EN
    logic [CW:0] sum;

    assign sum = {1'b0, err_count} + (CW+1)'(pc_q);
`else
    assign overflow = 1'b0;
`endif

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            err_count  <= '0;
            word_count <= '0;
            pc_q       <= '0;
            v_q        <= 1'b0;
`ifdef BER_SAT_EN
            overflow   <= 1'b0;
`endif
        end else if (restart) begin
            state      <= RUN;
            err_count  <= '0;
            word_count <= '0;
            v_q        <= 1'b0;
`ifdef BER_SAT_EN
            overflow   <= 1'b0;
`endif
        end else begin
            if (v_q) begin
`ifdef BER_SAT_EN
                if (sum[CW]) begin
                    err_count <= '1;
                    overflow  <= 1'b1;
                end else begin
                    err_count <= sum[CW-1:0];
                end
`else
                err_count <= err_count + CW'(pc_q);
`endif
            end

            v_q <= accept;
            if (accept) begin
                pc_q       <= pc_d;
                word_count <= word_count + WCW'(1);
            end

            case (state)
                RUN:     if (accept && (word_count == WCW'(WIN_WORDS - 1))) state <= DRAIN;
                DRAIN:   state <= DONE;
                DONE:    state <= IDLE;
                default: state <= state;
            endcase
        end
    end

endmodule

// File: tb/tb_ber_window_counter.sv
// Self-checking bench: two ber_window_counter instances (WIN=4/CW=32 and WIN=16/CW=8) on shared stimulus.
module tb_ber_window_counter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [31:0] tx_word;
    logic [31:0] rx_word;

    logic        ready_a, busy_a, done_a, ovf_a;
    logic [31:0] err_a;
    logic [2:0]  wc_a;
    logic        ready_b, busy_b, done_b, ovf_b;
    logic [7:0]  err_b;
    logic [4:0]  wc_b;

    int vectors = 0;
    int errors  = 0;

    ber_window_counter #(.W(32), .WIN_WORDS(4), .CW(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(ready_a),
        .tx_word(tx_word), .rx_word(rx_word), .err_count(err_a), .word_count(wc_a),
        .busy(busy_a), .done(done_a), .overflow(ovf_a)
    );

    ber_window_counter #(.W(32), .WIN_WORDS(16), .CW(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(ready_b),
        .tx_word(tx_word), .rx_word(rx_word), .err_count(err_b), .word_count(wc_b),
        .busy(busy_b), .done(done_b), .overflow(ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each window is a running total of error bits, with one-edge
    // pipeline delay; wrap/saturation is applied only when the output is formed.
    localparam int WIN_K [2] = '{4, 16};
    localparam int CW_K  [2] = '{32, 8};

    bit     m_open  [2];
    bit     m_drain [2];
    bit     m_done  [2];
    int     m_cnt   [2];
    longint m_total [2];
    int     m_pend  [2];
    bit     model_ok = 1'b0;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_open[k] = 0; m_drain[k] = 0; m_done[k] = 0;
                m_cnt[k] = 0; m_total[k] = 0; m_pend[k] = -1;
            end else if (start && !m_drain[k]) begin
                m_open[k] = 1; m_drain[k] = 0; m_done[k] = 0;
                m_cnt[k] = 0; m_total[k] = 0; m_pend[k] = -1;
            end else begin
                if (m_pend[k] >= 0) m_total[k] += m_pend[k];
                m_pend[k]  = -1;
                m_done[k]  = m_drain[k];
                m_drain[k] = 0;
                if (m_open[k] && in_valid) begin
                    m_pend[k] = $countones(tx_word ^ rx_word);
                    m_cnt[k]++;
                    if (m_cnt[k] == WIN_K[k]) begin
                        m_open[k]  = 0;
                        m_drain[k] = 1;
                    end
                end
            end
        end
        if (!rst_n) model_ok = 1'b1;
    end

    function automatic logic [63:0] exp_err(input longint total, input int cw);
        longint mx;
        mx = (longint'(1) << cw) - 1;
`ifdef BER_SAT_EN
        return (total > mx) ? mx : total;
`else
        return total & mx;
`endif
    endfunction

    function automatic logic exp_ovf(input longint total, input int cw);
`ifdef BER_SAT_EN
        return total > ((longint'(1) << cw) - 1);
`else
        return 1'b0;
`endif
    endfunction

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (model_ok) begin
            check("a.in_ready", ready_a, m_open[0] && !start);
            check("a.busy",     busy_a,  m_open[0] || m_drain[0]);
            check("a.done",     done_a,  m_done[0]);
            check("a.err",      err_a,   exp_err(m_total[0], CW_K[0]));
            check("a.words",    wc_a,    m_cnt[0]);
            check("a.overflow", ovf_a,   exp_ovf(m_total[0], CW_K[0]));
            check("b.in_ready", ready_b, m_open[1] && !start);
            check("b.busy",     busy_b,  m_open[1] || m_drain[1]);
            check("b.done",     done_b,  m_done[1]);
            check("b.err",      err_b,   exp_err(m_total[1], CW_K[1]));
            check("b.words",    wc_b,    m_cnt[1]);
            check("b.overflow", ovf_b,   exp_ovf(m_total[1], CW_K[1]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; in_valid = 1'b0;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic [31:0] err_pattern);
        tx_word  = $urandom;
        rx_word  = tx_word ^ err_pattern;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    logic [31:0] gap_pat [4];

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; tx_word = '0; rx_word = '0;
        gap_pat[0] = 32'h1; gap_pat[1] = 32'h3; gap_pat[2] = 32'h8000_0000; gap_pat[3] = 32'h0;
        repeat (2) tick();
        check("reset.err",      err_a,   32'd0);
        check("reset.in_ready", ready_a, 1'b0);
        check("reset.busy",     busy_a,  1'b0);
        rst_n = 1'b1;
        tick();

        // Matching words back-to-back.
        pulse_start();
        tx_word = 32'hA5A5_A5A5; rx_word = 32'hA5A5_A5A5; in_valid = 1'b1;
        repeat (4) tick();
        in_valid = 1'b0;
        check("t1.done_early", done_a, 1'b0);
        tick();
        check("t1.done",  done_a, 1'b1);
        check("t1.err",   err_a,  32'd0);
        check("t1.words", wc_a,   3'd4);
        tick();

        // All bits wrong.
        pulse_start();
        for (int i = 0; i < 4; i++) beat(32'hFFFF_FFFF);
        tick();
        check("t2.done", done_a, 1'b1);
        check("t2.err",  err_a,  32'd128);
        tick();
        check("t2.busy_after", busy_a, 1'b0);
        check("t2.hold_err",   err_a,  32'd128);

        // Sparse beats with gaps.
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            beat(gap_pat[i]);
            if (i < 3) begin
                repeat (3) begin
                    check("t3.in_ready_gap", ready_a, 1'b1);
                    tick();
                end
            end
        end
        tick();
        check("t3.done", done_a, 1'b1);
        check("t3.err",  err_a,  32'd4);

        // Restart mid-window; beat offered with start is dropped.
        tick();
        pulse_start();
        beat(32'hF);
        beat(32'hF);
        tx_word = 32'h0; rx_word = 32'hF; in_valid = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 4; i++) beat(32'h1);
        tick();
        check("t4.done",  done_a, 1'b1);
        check("t4.err",   err_a,  32'd4);
        check("t4.words", wc_a,   3'd4);
        repeat (2) tick();

        // 16 all-wrong beats into the CW=8 instance.
        pulse_start();
        tx_word = 32'h1234_5678; rx_word = ~tx_word; in_valid = 1'b1;
        repeat (16) tick();
        in_valid = 1'b0;
        tick();
        check("sat.done",  done_b, 1'b1);
        check("sat.words", wc_b,   5'd16);
`ifdef BER_SAT_EN
        check("sat.err",      err_b, 8'd255);
        check("sat.overflow", ovf_b, 1'b1);
`else
        check("sat.err",      err_b, 8'd0);
        check("sat.overflow", ovf_b, 1'b0);
`endif
        repeat (2) tick();

        // Reset mid-window.
        pulse_start();
        beat(32'hFF);
        beat(32'hFF);
        rst_n = 1'b0;
        tick();
        check("rst.err_a",   err_a,   32'd0);
        check("rst.words_a", wc_a,    3'd0);
        check("rst.ready_a", ready_a, 1'b0);
        check("rst.busy_a",  busy_a,  1'b0);
        check("rst.err_b",   err_b,   8'd0);
        check("rst.words_b", wc_b,    5'd0);
        rst_n = 1'b1;
        tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            rst_n    = ($urandom_range(0, 299) != 0);
            start    = ($urandom_range(0, 39) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            tx_word  = $urandom;
            rx_word  = tx_word ^ ($urandom_range(0, 1) ? $urandom : ($urandom & $urandom & $urandom));
            tick();
        end
        rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
